// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with fetch-side prediction, EX-side resolution,
// mispredict redirect and a saturating mispredict counter.
module branch_target_buffer #(
    parameter int idx_offset = 6,
    parameter int idx_length = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr_fetch,
    input  logic        pred_taken,
    input  logic        pipe_advance,
    input  logic [31:0] pc_addr_ex,
    input  logic [6:0]  opcode,
    input  logic        br_en,
    input  logic [31:0] br_target_ex,
    output logic [31:0] next_pc,
    output logic        btb_hit,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        tournament_update,
    output logic [15:0] mispredict_count
);
    localparam int ENTRIES = 2 ** idx_length;
    localparam int TAG_W   = 31 - idx_offset;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic        dec_vld_q, dec_vld_d, dec_tk_q, dec_tk_d;
    logic [31:0] dec_tgt_q, dec_tgt_d;
    logic        ex_vld_q, ex_vld_d, ex_tk_q, ex_tk_d;
    logic [31:0] ex_tgt_q, ex_tgt_d;
    logic [15:0] mispredict_q, mispredict_d;

    logic [idx_length-1:0] f_idx, x_idx;
    logic [TAG_W-1:0]      f_tag, x_tag;
    logic                  is_br, is_jmp, taken, bt_we;
    logic [31:0]           ex_seq, actual_next, pred_next;

    assign f_idx = pc_addr_fetch[idx_offset -: idx_length];
    assign f_tag = pc_addr_fetch[31:idx_offset+1];
    assign x_idx = pc_addr_ex[idx_offset -: idx_length];
    assign x_tag = pc_addr_ex[31:idx_offset+1];

    assign btb_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign next_pc = (btb_hit && pred_taken) ? tgt_q[f_idx] : pc_addr_fetch + 32'd4;

    assign is_br       = (opcode == OP_BRANCH);
    assign is_jmp      = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign taken       = is_jmp || (is_br && br_en);
    assign ex_seq      = pc_addr_ex + 32'd4;
    assign actual_next = taken ? br_target_ex : ex_seq;
    assign pred_next   = ex_tk_q ? ex_tgt_q : ex_seq;

    // Non-control-flow opcodes never redirect; any stale prediction simply drops out.
    assign redirect          = pipe_advance && ex_vld_q && (is_br || is_jmp) && (actual_next != pred_next);
    assign redirect_pc       = redirect ? actual_next : 32'd0;
    assign tournament_update = pipe_advance && ex_vld_q && is_br;
    assign bt_we             = pipe_advance && ex_vld_q && taken;
    assign mispredict_count  = mispredict_q;

    always_comb begin
        valid_d      = valid_q;
        dec_vld_d    = dec_vld_q;
        dec_tk_d     = dec_tk_q;
        dec_tgt_d    = dec_tgt_q;
        ex_vld_d     = ex_vld_q;
        ex_tk_d      = ex_tk_q;
        ex_tgt_d     = ex_tgt_q;
        mispredict_d = mispredict_q;
        if (pipe_advance) begin
            dec_vld_d = 1'b1;
            dec_tk_d  = btb_hit && pred_taken;
            dec_tgt_d = tgt_q[f_idx];
            ex_vld_d  = dec_vld_q;
            ex_tk_d   = dec_tk_q;
            ex_tgt_d  = dec_tgt_q;
        end
        // Instructions younger than a mispredicted one are on the wrong path.
        if (redirect) begin
            dec_vld_d = 1'b0;
            ex_vld_d  = 1'b0;
            if (mispredict_q != 16'hFFFF) begin
                mispredict_d = mispredict_q + 16'd1;
            end
        end
        if (bt_we) begin
            valid_d[x_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= '0;
            dec_vld_q    <= 1'b0;
            dec_tk_q     <= 1'b0;
            dec_tgt_q    <= 32'd0;
            ex_vld_q     <= 1'b0;
            ex_tk_q      <= 1'b0;
            ex_tgt_q     <= 32'd0;
            mispredict_q <= 16'd0;
        end else begin
            valid_q      <= valid_d;
            dec_vld_q    <= dec_vld_d;
            dec_tk_q     <= dec_tk_d;
            dec_tgt_q    <= dec_tgt_d;
            ex_vld_q     <= ex_vld_d;
            ex_tk_q      <= ex_tk_d;
            ex_tgt_q     <= ex_tgt_d;
            mispredict_q <= mispredict_d;
        end
    end

    // Tag/target storage needs no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (bt_we) begin
            tag_q[x_idx] <= x_tag;
            tgt_q[x_idx] <= br_target_ex;
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Randomized and directed bench for branch_target_buffer against a behavioural model.
module tb_branch_target_buffer;
    localparam logic [6:0] NOP  = 7'h13;
    localparam logic [6:0] BR   = 7'h63;
    localparam logic [6:0] JAL  = 7'h6F;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] ALU  = 7'h33;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr_fetch, pc_addr_ex, br_target_ex;
    logic        pred_taken, pipe_advance, br_en;
    logic [6:0]  opcode;
    logic [31:0] next_pc, redirect_pc;
    logic        btb_hit, redirect, tournament_update;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk(clk), .rst(rst),
        .pc_addr_fetch(pc_addr_fetch), .pred_taken(pred_taken), .pipe_advance(pipe_advance),
        .pc_addr_ex(pc_addr_ex), .opcode(opcode), .br_en(br_en), .br_target_ex(br_target_ex),
        .next_pc(next_pc), .btb_hit(btb_hit), .redirect(redirect), .redirect_pc(redirect_pc),
        .tournament_update(tournament_update), .mispredict_count(mispredict_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: table by index, plus the two in-flight prediction slots (0 = decode, 1 = EX).
    bit          m_v   [16];
    int unsigned m_tag [16];
    int unsigned m_tgt [16];
    bit          s_v   [2];
    bit          s_tk  [2];
    int unsigned s_tgt [2];
    int unsigned m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        for (int i = 0; i < 2; i++) begin
            s_v[i] = 0; s_tk[i] = 0; s_tgt[i] = 0;
        end
        m_cnt = 0;
    endfunction

    task automatic cyc(input logic [31:0] pcf, input bit pt, input bit adv,
                       input logic [31:0] pcx, input logic [6:0] opc, input bit br,
                       input logic [31:0] tgt);
        int unsigned fi, xi, hit_tgt, actual, predn;
        bit hit, cond, jmp, tk, e_red, e_upd;
        @(negedge clk);
        pc_addr_fetch = pcf; pred_taken = pt; pipe_advance = adv;
        pc_addr_ex = pcx; opcode = opc; br_en = br; br_target_ex = tgt;
        #2;
        fi      = (pcf / 8) % 16;
        hit     = m_v[fi] && (m_tag[fi] == pcf / 128);
        hit_tgt = m_tgt[fi];
        cond    = (opc == BR);
        jmp     = (opc == JAL) || (opc == JALR);
        tk      = jmp || (cond && br);
        actual  = tk ? tgt : pcx + 4;
        predn   = s_tk[1] ? s_tgt[1] : pcx + 4;
        e_red   = adv && s_v[1] && (cond || jmp) && (actual != predn);
        e_upd   = adv && s_v[1] && cond;
        chk("btb_hit", btb_hit, hit);
        chk("next_pc", next_pc, (hit && pt) ? hit_tgt : pcf + 4);
        chk("redirect", redirect, e_red);
        chk("redirect_pc", redirect_pc, e_red ? actual : 0);
        chk("tournament_update", tournament_update, e_upd);
        chk("mispredict_count", mispredict_count, m_cnt);
        if (adv) begin
            if (s_v[1] && tk) begin
                xi = (pcx / 8) % 16;
                m_v[xi] = 1; m_tag[xi] = pcx / 128; m_tgt[xi] = tgt;
            end
            s_v[1] = s_v[0]; s_tk[1] = s_tk[0]; s_tgt[1] = s_tgt[0];
            s_v[0] = 1; s_tk[0] = hit && pt; s_tgt[0] = hit_tgt;
            if (e_red) begin
                s_v[0] = 0; s_v[1] = 0;
                if (m_cnt < 65535) m_cnt++;
            end
        end
    endtask

    function automatic logic [31:0] rnd_pc();
        int unsigned tags [4] = '{0, 1, 2, 16};
        return (tags[$urandom_range(0, 3)] << 7) | ($urandom_range(0, 3) << 3) | ($urandom_range(0, 1) << 2);
    endfunction

    function automatic logic [6:0] rnd_op();
        logic [6:0] ops [5] = '{BR, BR, JAL, JALR, ALU};
        return ops[$urandom_range(0, 4)];
    endfunction

    initial begin
        model_reset();
        rst = 1'b0;
        pc_addr_fetch = 32'h40; pred_taken = 1; pipe_advance = 1;
        pc_addr_ex = 32'h40; opcode = BR; br_en = 1; br_target_ex = 32'h100;
        @(negedge clk); #2;
        chk("rst_hit", btb_hit, 0);
        chk("rst_next_pc", next_pc, 32'h44);
        chk("rst_redirect", redirect, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_update", tournament_update, 0);
        chk("rst_count", mispredict_count, 0);
        pipe_advance = 0;
        @(negedge clk); #1 rst = 1'b1;

        // Cold miss, then taken branch learned after a redirect.
        cyc(32'h40, 1, 1, 0, NOP, 0, 0);
        chk("cold_hit", btb_hit, 0); chk("cold_next", next_pc, 32'h44);
        cyc(32'h44, 0, 1, 0, NOP, 0, 0);
        cyc(32'h48, 0, 1, 32'h40, BR, 1, 32'h100);
        chk("tk_red", redirect, 1); chk("tk_rpc", redirect_pc, 32'h100); chk("tk_upd", tournament_update, 1);
        cyc(32'h40, 1, 1, 0, NOP, 0, 0);
        chk("tk_cnt", mispredict_count, 1); chk("learn_hit", btb_hit, 1); chk("learn_next", next_pc, 32'h100);
        // Predicted taken, resolves not taken: entry kept.
        cyc(32'h100, 0, 1, 0, NOP, 0, 0);
        cyc(32'h104, 0, 1, 32'h40, BR, 0, 32'h100);
        chk("nt_red", redirect, 1); chk("nt_rpc", redirect_pc, 32'h44);
        cyc(32'h40, 1, 1, 0, NOP, 0, 0);
        chk("nt_cnt", mispredict_count, 2); chk("nt_keep_hit", btb_hit, 1);
        // Aliasing on index 8.
        cyc(32'h840, 1, 1, 0, NOP, 0, 0);
        chk("alias_hit", btb_hit, 0); chk("alias_next", next_pc, 32'h844);
        cyc(32'h844, 0, 1, 32'h40, NOP, 0, 0);
        chk("nop_tk_no_red", redirect, 0);
        cyc(32'h200, 0, 1, 32'h840, JAL, 0, 32'h200);
        chk("jal_red", redirect, 1); chk("jal_rpc", redirect_pc, 32'h200);
        cyc(32'h40, 1, 1, 0, NOP, 0, 0);
        chk("evicted_hit", btb_hit, 0); chk("evicted_next", next_pc, 32'h44);
        cyc(32'h840, 1, 1, 0, NOP, 0, 0);
        chk("replaced_next", next_pc, 32'h200);
        // Wrong-path branch squashed by a jalr redirect.
        cyc(32'h80, 0, 1, 0, NOP, 0, 0);
        cyc(32'h88, 0, 1, 0, NOP, 0, 0);
        cyc(32'h8C, 0, 1, 32'h80, JALR, 0, 32'h300);
        chk("jalr_rpc", redirect_pc, 32'h300);
        cyc(32'h300, 0, 1, 0, NOP, 0, 0);
        cyc(32'h304, 0, 1, 32'h88, BR, 1, 32'h400);
        chk("wp_red", redirect, 0); chk("wp_upd", tournament_update, 0);
        cyc(32'h88, 1, 1, 0, NOP, 0, 0);
        chk("wp_no_write", btb_hit, 0);
        // Stall: a mispredicting branch waits in EX.
        for (int i = 0; i < 3; i++) begin
            cyc(32'h8C, 0, 0, 32'h304, BR, 1, 32'h500);
            chk("stall_red", redirect, 0); chk("stall_upd", tournament_update, 0);
            chk("stall_cnt", mispredict_count, 4);
        end
        cyc(32'h8C, 0, 1, 32'h304, BR, 1, 32'h500);
        chk("unstall_red", redirect, 1); chk("unstall_rpc", redirect_pc, 32'h500);
        cyc(32'h304, 1, 1, 0, NOP, 0, 0);
        chk("unstall_next", next_pc, 32'h500);

        for (int i = 0; i < 800; i++) begin
            cyc(rnd_pc(), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                rnd_pc(), rnd_op(), 1'($urandom_range(0, 1)), 32'h1000 + ($urandom_range(0, 15) << 4));
        end

        // Asynchronous reset between edges, with a taken jal pending in EX.
        cyc(32'h40, 1, 1, 0, NOP, 0, 0);
        @(negedge clk);
        pc_addr_fetch = 32'h840; pred_taken = 1; pipe_advance = 1;
        pc_addr_ex = 32'h840; opcode = JAL; br_en = 0; br_target_ex = 32'h900;
        #2 rst = 1'b0;
        #1;
        chk("arst_hit", btb_hit, 0); chk("arst_next", next_pc, 32'h844);
        chk("arst_red", redirect, 0); chk("arst_rpc", redirect_pc, 0);
        chk("arst_upd", tournament_update, 0); chk("arst_cnt", mispredict_count, 0);
        @(posedge clk);
        @(negedge clk); pipe_advance = 0;
        #1 rst = 1'b1;
        model_reset();
        cyc(32'h40, 1, 1, 0, NOP, 0, 0);   chk("post_rst_40", btb_hit, 0);
        cyc(32'h840, 1, 1, 0, NOP, 0, 0);  chk("post_rst_840", btb_hit, 0);
        cyc(32'h304, 1, 1, 0, NOP, 0, 0);  chk("post_rst_304", btb_hit, 0);
        cyc(32'h8, 1, 1, 0, NOP, 0, 0);    chk("post_rst_8", btb_hit, 0);

        // Preload the counter near its ceiling instead of running tens of thousands of mispredicts.
        cyc(32'h10, 0, 1, 0, NOP, 0, 0);
        force dut.mispredict_q = 16'hFFFC;
        m_cnt = 32'hFFFC;
        cyc(32'h14, 0, 1, 0, NOP, 0, 0);
        release dut.mispredict_q;
        for (int i = 0; i < 15; i++) begin
            cyc(rnd_pc(), 0, 1, rnd_pc(), JAL, 0, 32'h7000 + (i << 4));
        end
        cyc(32'h18, 0, 1, 0, NOP, 0, 0);
        chk("sat_cnt", mispredict_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter idx_offset, default 6, MSB of the PC index field.
REQ-002 SHALL have parameter idx_length, default 4, index width; entries = 2**idx_length.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pc_addr_fetch  input  32  PC in fetch.
REQ-006 SHALL have port pred_taken  input  1  direction prediction for pc_addr_fetch, from the tournament predictor.
REQ-007 SHALL have port pipe_advance  input  1  1 = fetch/decode/EX registers advance this cycle.
REQ-008 SHALL have port pc_addr_ex  input  32  PC of instruction in EX.
REQ-009 SHALL have port opcode  input  7  opcode of instruction in EX.
REQ-010 SHALL have port br_en  input  1  resolved direction in EX (conditional branches).
REQ-011 SHALL have port br_target_ex  input  32  resolved target in EX.
REQ-012 SHALL have ports next_pc (output, 32, fetch next PC), btb_hit (output, 1), redirect (output, 1, mispredict flush), redirect_pc (output, 32, correct PC), tournament_update (output, 1, predictor update strobe) and mispredict_count (output, 16, saturating count).

Function
REQ-013 SHALL hold 2**idx_length entries, each {valid, tag = pc[31:idx_offset+1], target[31:0]}, indexed by pc[idx_offset:idx_offset-idx_length+1].
REQ-014 SHALL compute btb_hit combinationally = valid & tag match for pc_addr_fetch.
REQ-015 SHALL drive next_pc = (btb_hit & pred_taken) ? entry target : pc_addr_fetch+4, combinationally, mod 2**32.
REQ-016 SHALL carry {valid, pred_tk = btb_hit & pred_taken, pred_tgt} through decode and EX registers, loaded only when pipe_advance=1; fetch slot is always valid.
REQ-017 SHALL classify the EX instruction as cond branch (1100011), jal (1101111), jalr (1100111); jal/jalr are always taken.
REQ-018 SHALL compute actual_next = taken ? br_target_ex : pc_addr_ex+4 and pred_next = pred_tk_ex ? pred_tgt_ex : pc_addr_ex+4.
REQ-019 SHALL assert redirect combinationally when ex_valid & control-flow opcode & actual_next != pred_next & pipe_advance; redirect_pc = actual_next whenever redirect=1, otherwise 0.
REQ-020 SHALL not assert redirect for a non-control-flow EX opcode, even if pred_tk_ex=1. The stale prediction is discarded silently.
REQ-021 SHALL assert tournament_update = ex_valid & cond branch & pipe_advance, one cycle per branch.
REQ-022 SHALL, on a clock edge with redirect=1, clear decode and EX valid bits. Wrong-path instructions then produce no redirect, no update and no BTB write.
REQ-023 SHALL write the entry for pc_addr_ex (valid=1, tag, target=br_target_ex) on ex_valid & pipe_advance & (jal | jalr | cond branch & br_en). A not-taken branch leaves its entry unchanged.
REQ-024 SHALL use read-before-write for a same-cycle read and write of the same index: fetch sees old contents, and the new contents are visible the next cycle.
REQ-025 SHALL increment mispredict_count on each redirect edge and saturate at 16'hFFFF.
REQ-026 SHALL hold all state when pipe_advance=0. The redirect and tournament_update outputs stay 0 in that case.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear all entry valid bits, decode/EX valid, pred_tk, pred_tgt and mispredict_count.
REQ-028 SHALL hold these reset output values: btb_hit=0, next_pc=pc_addr_fetch+4, redirect=0, redirect_pc=0, tournament_update=0, mispredict_count=0.
REQ-029 SHALL, on reset asserted mid-operation, abort any pending write and leave no entry valid after release.

Verification
REQ-030 Cold BTB: fetch 0x40 with pred_taken=1 -> btb_hit=0, next_pc=0x44.
REQ-031 Taken branch at 0x40 with target 0x100 reaches EX with br_en=1 -> redirect=1, redirect_pc=0x100, tournament_update=1, mispredict_count=1. Next fetch of 0x40 with pred_taken=1 -> btb_hit=1, next_pc=0x100.
REQ-032 Branch at 0x40 is a BTB hit and predicted taken, then resolves br_en=0 -> redirect=1, redirect_pc=0x44. Entry is kept, so btb_hit=1 on the next fetch.
REQ-033 Aliasing: 0x40 is cached, then 0x840 is fetched (same index, different tag) -> btb_hit=0. A jal at 0x840 to 0x200 then replaces the entry, and 0x40 misses afterwards.
REQ-034 Redirect with a wrong-path branch in decode -> that branch produces no tournament_update, no redirect and no write. With pipe_advance=0 for 3 cycles, all state holds and outputs stay 0.
REQ-035 Assert rst=0 asynchronously between edges -> all outputs take their reset values immediately, and every fetch misses after release. Forced 70000 mispredicts -> mispredict_count=16'hFFFF.
